// File: rtl/fetch_unit_if.sv
// Fetch front-end bundle: instruction-memory request/response, redirect, and the
// decode-side valid/ready handshake. "master" is the fetch unit, "slave" its environment.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// In-order instruction fetch with credit-limited requests, a DEPTH-entry
// {word, pc} queue toward decode, and redirect/flush that drops stale responses.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     q_data_q [DEPTH];
  logic [XLEN-1:0] q_pc_q   [DEPTH];

  logic [CW:0]     credit_used;
  logic [XLEN-1:0] redirect_base;
  logic            req, gnt, push, pop, drop_rsp;
  logic            unused_redirect_lsb;

  assign redirect_base       = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  // Queue slots and outstanding requests share one credit pool, so a
  // response always finds room and never needs back-pressure.
  assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};
  assign req         = rst & ~bus.redirect_valid & (credit_used < DEPTH_W);
  assign gnt         = req & bus.imem_gnt;
  assign drop_rsp    = bus.imem_rvalid & (drop_q != '0);
  assign push        = bus.imem_rvalid & ~bus.redirect_valid & (drop_q == '0);
  assign pop         = bus.inst_valid & bus.inst_ready & ~bus.redirect_valid;

  assign bus.imem_req   = req;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = (count_q != '0);
  assign bus.inst_data  = bus.inst_valid ? q_data_q[rd_ptr_q] : '0;
  assign bus.inst_pc    = bus.inst_valid ? q_pc_q[rd_ptr_q]   : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (bus.redirect_valid) begin
      // Everything still owed by memory, minus this cycle's response, is stale.
      fetch_pc_d = redirect_base;
      resp_pc_d  = redirect_base;
      inflight_d = inflight_q - CW'(bus.imem_rvalid);
      drop_d     = inflight_q - CW'(bus.imem_rvalid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (gnt) fetch_pc_d = fetch_pc_q + XLEN'(4);
      inflight_d = inflight_q + CW'(gnt) - CW'(bus.imem_rvalid);
      if (drop_rsp) drop_d = drop_q - CW'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + XLEN'(4);
        wr_ptr_d  = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Payload storage needs no reset; outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data_q[wr_ptr_q] <= bus.imem_rdata;
      q_pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: an in-order variable-latency memory model feeds a
// scoreboard of expected {pc, word} pairs that a separate monitor checks at decode.
module tb_fetch_unit;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN)) bif ();

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct { int due; logic [31:0] data; } rsp_t;

  exp_t sb[$];
  rsp_t pend[$];
  int checks = 0, errors = 0;
  int cyc = 0, grants = 0, pops = 0, outstanding = 0;
  int lat_min = 1, lat_max = 1, gnt_pct = 100;
  logic [31:0] exp_req = RESET_PC;
  logic saw_zero = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word_at(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: in-order responses after lat_min..lat_max cycles; grants push expectations.
  initial begin
    bif.imem_gnt = 1'b0; bif.imem_rvalid = 1'b0; bif.imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend.delete();
        outstanding = 0;
        bif.imem_rvalid = 1'b0;
        bif.imem_gnt = 1'b0;
      end else begin
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          bif.imem_rvalid = 1'b1;
          bif.imem_rdata = pend[0].data;
          void'(pend.pop_front());
          outstanding--;
        end else begin
          bif.imem_rvalid = 1'b0;
          bif.imem_rdata = $urandom;
        end
        bif.imem_gnt = ($urandom_range(99) < gnt_pct);
      end
      #1;
      if (rst && bif.imem_req && bif.imem_gnt) begin
        rsp_t r;
        check("imem_addr", {32'h0, bif.imem_addr}, {32'h0, exp_req});
        sb.push_back('{pc: exp_req, data: word_at(exp_req)});
        r.due = cyc + int'($urandom_range(lat_max, lat_min));
        r.data = word_at(bif.imem_addr);
        pend.push_back(r);
        exp_req = exp_req + 32'd4;
        outstanding++;
        grants++;
        check("inflight_bound", {63'h0, outstanding <= DEPTH}, 64'h1);
      end
    end
  end

  // Monitor: every accepted instruction must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst && !bif.redirect_valid && bif.inst_valid && bif.inst_ready) begin
        pops++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_inst: got pc %h expected none (cycle %0d)", bif.inst_pc, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("inst_pc", {32'h0, bif.inst_pc}, {32'h0, e.pc});
          check("inst_data", {32'h0, bif.inst_data}, {32'h0, e.data});
          if (e.pc == 32'h0) saw_zero = 1'b1;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    sb.delete();
    exp_req = RESET_PC;
    grants = 0;
    pops = 0;
    #1;
    check("rst_imem_req", {63'h0, bif.imem_req}, 64'h0);
    check("rst_imem_addr", {32'h0, bif.imem_addr}, {32'h0, RESET_PC});
    check("rst_inst_valid", {63'h0, bif.inst_valid}, 64'h0);
    check("rst_inst_data", {32'h0, bif.inst_data}, 64'h0);
    check("rst_inst_pc", {32'h0, bif.inst_pc}, 64'h0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("first_req", {63'h0, bif.imem_req}, 64'h1);
    check("first_addr", {32'h0, bif.imem_addr}, {32'h0, RESET_PC});
  endtask

  // Called at a falling edge so the memory model and monitor see it this cycle.
  task automatic redirect(logic [31:0] pc);
    bif.redirect_valid = 1'b1;
    bif.redirect_pc = pc;
    sb.delete();
    exp_req = {pc[31:2], 2'b00};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int p0;
    bif.redirect_valid = 1'b0;
    bif.redirect_pc = '0;
    bif.inst_ready = 1'b0;

    // Streaming, 1-cycle memory
    do_reset();
    bif.inst_ready = 1'b1;
    release_reset();
    @(negedge clk);
    @(negedge clk); #2;
    check("stream_not_yet", {63'h0, bif.inst_valid}, 64'h0);
    @(negedge clk); #2;
    check("stream_first_valid", {63'h0, bif.inst_valid}, 64'h1);
    check("stream_first_pc", {32'h0, bif.inst_pc}, {32'h0, RESET_PC});
    cnt = 0;
    repeat (16) begin
      @(negedge clk); #2;
      if (bif.inst_valid) cnt++;
    end
    check("stream_throughput", cnt, 16);

    // Back-pressure: ready low from reset
    bif.inst_ready = 1'b0;
    do_reset();
    release_reset();
    repeat (12) @(negedge clk);
    #2;
    check("bp_grants", grants, DEPTH);
    check("bp_req_low", {63'h0, bif.imem_req}, 64'h0);
    check("bp_valid", {63'h0, bif.inst_valid}, 64'h1);
    @(negedge clk);
    bif.inst_ready = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    check("bp_drained", {63'h0, pops >= DEPTH}, 64'h1);

    // Redirect with several responses outstanding (3-cycle memory)
    lat_min = 3; lat_max = 3;
    do_reset();
    release_reset();
    repeat (12) @(negedge clk);
    redirect(32'h0000_2003);
    #2;
    check("redir_req_low", {63'h0, bif.imem_req}, 64'h0);
    @(negedge clk);
    bif.redirect_valid = 1'b0;
    #2;
    check("redir_valid_drop", {63'h0, bif.inst_valid}, 64'h0);
    p0 = pops;
    repeat (12) @(negedge clk);
    #2;
    check("redir_progress", {63'h0, pops > p0}, 64'h1);

    // Back-to-back redirects coinciding with rvalid and pop, 1-cycle memory
    lat_min = 1; lat_max = 1;
    repeat (8) @(negedge clk);
    redirect(32'h0000_4000);
    @(negedge clk);
    redirect(32'h0000_8000);
    @(negedge clk);
    bif.redirect_valid = 1'b0;
    #2;
    check("r2_t1_valid", {63'h0, bif.inst_valid}, 64'h0);
    check("r2_t1_req", {63'h0, bif.imem_req}, 64'h1);
    check("r2_t1_addr", {32'h0, bif.imem_addr}, 64'h8000);
    @(negedge clk); #2;
    check("r2_t2_valid", {63'h0, bif.inst_valid}, 64'h0);
    @(negedge clk); #2;
    check("r2_t3_valid", {63'h0, bif.inst_valid}, 64'h1);
    check("r2_t3_pc", {32'h0, bif.inst_pc}, 64'h8000);

    // Random latency, grant, ready and redirects
    lat_min = 1; lat_max = 5; gnt_pct = 70;
    repeat (400) begin
      @(negedge clk);
      bif.inst_ready = ($urandom_range(99) < 70);
      if ($urandom_range(99) < 4) redirect($urandom);
      else bif.redirect_valid = 1'b0;
    end
    @(negedge clk);
    bif.redirect_valid = 1'b0;
    bif.inst_ready = 1'b1;
    repeat (30) @(negedge clk);
    #2;
    check("sb_bounded", {63'h0, sb.size() <= DEPTH}, 64'h1);

    // PC wrap, then reset in mid-stream
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    @(negedge clk);
    saw_zero = 1'b0;
    redirect(32'hFFFF_FFF8);
    @(negedge clk);
    bif.redirect_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    check("wrap_seen_zero", {63'h0, saw_zero}, 64'h1);
    do_reset();
    release_reset();
    repeat (10) @(negedge clk);
    #2;
    check("restart_progress", {63'h0, pops > 4}, 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end replacing the free-running PC register, +4 adder and combinational instruction-memory read of the single-cycle datapath. It issues in-order word requests to a handshaked instruction memory of arbitrary latency and buffers returned words with their PCs in a DEPTH-entry queue. It presents instructions to decode over a valid/ready handshake and supports stall and redirect/flush, which prepares the core for pipelining.

## Interface
- XLEN, 32, PC/address width (≥ 8)
- DEPTH, 4, queue entries and maximum in-flight credit; power of two, ≥ 2
- RESET_PC, 0, first fetch address after reset; word-aligned
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  request valid
- imem_addr  out  XLEN  request word address; bits [1:0] always 0
- imem_gnt  in  1  memory accepts the request when imem_req & imem_gnt
- imem_rvalid  in  1  response valid; responses return in request order, latency ≥ 1 cycle
- imem_rdata  in  32  response instruction word
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored (treated as 0)
- inst_valid  out  1  queue head valid
- inst_ready  in  1  decode accepts the head when inst_valid & inst_ready
- inst_data  out  32  head instruction
- inst_pc  out  XLEN  PC of the head instruction

## Operation
- State: fetch_pc (next request address), resp_pc (PC of the next kept response), inflight counter, drop counter, circular queue with rd/wr pointers and a count (width clog2(DEPTH)+1).
- Credit rule: imem_req = 1 iff count + inflight < DEPTH, redirect_valid = 0 and rst is released. A full queue therefore always has inflight = 0, and a response is never refused.
- Grant: fetch_pc += 4 and inflight += 1. An rvalid in the same cycle is netted against the grant.
- Response with drop = 0: push {imem_rdata, resp_pc}, then resp_pc += 4. Response with drop > 0: discard the word and decrement drop. Every response decrements inflight.
- Pop: on inst_valid & inst_ready, advance rd and decrement count. Push and pop may occur in the same cycle.
- Redirect (priority over everything):
  - Queue cleared (count = 0, pointers equal).
  - fetch_pc and resp_pc load {redirect_pc[XLEN-1:2], 2'b00}.
  - drop loads inflight minus the rvalid of this cycle. Any rvalid in the redirect cycle is discarded.
  - imem_req is 0 and any pop is ignored.
  - Back-to-back redirects are legal; the last one wins.
- PC arithmetic is modulo 2^XLEN (wraps from all-ones-minus-3 to 0).
- Outputs are driven from registered queue state only; there is no combinational path from imem_rvalid to inst_valid.

## Timing
- Reset values:
  - imem_req = 0, imem_addr = RESET_PC, inst_valid = 0, inst_data = 0, inst_pc = 0.
  - Counters are 0 and fetch_pc = resp_pc = RESET_PC.
- The first cycle after reset deasserts has imem_req = 1 and imem_addr = RESET_PC.
- With a 1-cycle memory and continuous gnt/ready: grant at cycle t, rvalid at t+1, inst_valid at t+2. Throughput is one instruction per cycle.
- Redirect at cycle t:
  - inst_valid = 0 at t+1.
  - Request for redirect_pc at t+1.
  - With a 1-cycle memory, first kept instruction is valid at t+3.
- Reset asserted mid-operation immediately returns all state to reset values. Responses still in flight at that point are the memory's responsibility to cancel.

## Test plan
- Streaming: 1-cycle memory, gnt = ready = 1, RESET_PC = 0x100 → inst_pc 0x100, 0x104, 0x108 … on consecutive cycles starting two cycles after the first request.
- Back-pressure: hold inst_ready = 0 for 10 cycles with DEPTH = 4 → exactly 4 requests issued, imem_req = 0 afterwards, no lost or duplicated words; releasing ready drains them in order.
- Variable latency: responses returned with 1–5 cycle random delay and random gnt → order and PC pairing preserved, inflight never exceeds DEPTH.
- Redirect with 3 in flight: redirect_pc = 0x2003 → the 3 stale responses are discarded; the next inst_pc is 0x2000, then 0x2004.
- Redirect in the same cycle as rvalid and a pop, then a second redirect the next cycle → only the second target's instructions appear.
- Wrap: XLEN = 8, RESET_PC = 0xF8 → inst_pc 0xF8, 0xFC, 0x00; mid-stream rst = 0 → inst_valid = 0 immediately, restart at 0xF8.
